rf_wb_sched: RTL and testbench

RF_WB_SCHED -- requirements
Module: rf_wb_sched

---
 rtl/rf_wb_sched_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/rf_wb_sched.sv | 99 +++++++++
 tb/tb_rf_wb_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_sched_pkg.sv
// rf_wb_sched_pkg: shared core constants for register width, register count and write-back requester indices.
package rf_wb_sched_pkg;

    localparam int CFG_XLEN     = 32;
    localparam int CFG_REG_AW   = 5;
    localparam int CFG_NUM_REGS = 1 << CFG_REG_AW;
    localparam int CFG_NUM_REQ  = 3;

    typedef enum logic [1:0] {
        REQ_EX     = 2'd0,
        REQ_LSU    = 2'd1,
        REQ_MULDIV = 2'd2
    } wb_req_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant; the search starts at ptr_i and wraps modulo N.
//   req_i       : per-requester request
//   ptr_i       : highest-priority requester this cycle
//   grant_o     : one-hot grant (zero when no request)
//   grant_idx_o : index of the granted requester (0 when no request)
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    // Walk the priority order backwards so the requester closest to ptr_i is the last, winning assignment.
    always_comb begin
        int idx;
        idx         = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr_i) + i) % N;
            if (req_i[idx]) begin
                grant_o     = N'(1) << idx;
                grant_idx_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: write-back port arbitration into the register file plus a pending-write scoreboard for issue stalls.
//   wb_valid_i/wb_addr_i/wb_data_i : per-requester write-back requests (slice k = requester k)
//   wb_ready_o                     : combinational one-hot accept
//   rf_wr_en_o/addr_o/data_o       : registered register-file write port
//   iss_valid_i/rd/rs1/rs2         : instruction being issued by ID
//   iss_stall_o                    : hold the issuing instruction
//   busy_o                         : bit n set = write to xn pending
module rf_wb_sched
    import rf_wb_sched_pkg::*;
#(
    parameter int NUM_REQ = CFG_NUM_REQ,
    parameter int XLEN    = CFG_XLEN,
    parameter int REG_AW  = CFG_REG_AW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        wb_valid_i,
    input  logic [NUM_REQ*REG_AW-1:0] wb_addr_i,
    input  logic [NUM_REQ*XLEN-1:0]   wb_data_i,
    output logic [NUM_REQ-1:0]        wb_ready_o,
    output logic                      rf_wr_en_o,
    output logic [REG_AW-1:0]         rf_wr_addr_o,
    output logic [XLEN-1:0]           rf_wr_data_o,
    input  logic                      iss_valid_i,
    input  logic [REG_AW-1:0]         iss_rd_i,
    input  logic [REG_AW-1:0]         iss_rs1_i,
    input  logic [REG_AW-1:0]         iss_rs2_i,
    output logic                      iss_stall_o,
    output logic [(1<<REG_AW)-1:0]    busy_o
);

    localparam int NREG = 1 << REG_AW;
    localparam int IW   = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]      rr_ptr_q, rr_ptr_d, gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               xfer;
    logic [REG_AW-1:0]  g_addr;
    logic [XLEN-1:0]    g_data;
    logic               wr_en_q, wr_en_d;
    logic [REG_AW-1:0]  wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]    wr_data_q, wr_data_d;
    logic [NREG-1:0]    busy_q, busy_d, busy_eff, clr_mask, set_mask;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i       (wb_valid_i),
        .ptr_i       (rr_ptr_q),
        .grant_o     (gnt),
        .grant_idx_o (gnt_idx)
    );

    // Nothing is accepted while reset is held, so requests in flight are dropped.
    assign wb_ready_o = rst_n ? gnt : '0;
    assign xfer       = |(wb_valid_i & wb_ready_o);
    assign g_addr     = wb_addr_i[int'(gnt_idx)*REG_AW +: REG_AW];
    assign g_data     = wb_data_i[int'(gnt_idx)*XLEN +: XLEN];

    // The register file bypasses the write currently on the port, so that bit no longer blocks issue.
    assign clr_mask = wr_en_q ? NREG'(1) << wr_addr_q : '0;
    assign busy_eff = busy_q & ~clr_mask;

    assign iss_stall_o = rst_n && iss_valid_i &&
                         ((|iss_rs1_i && busy_eff[iss_rs1_i]) ||
                          (|iss_rs2_i && busy_eff[iss_rs2_i]) ||
                          (|iss_rd_i  && busy_eff[iss_rd_i]));

    assign set_mask = (iss_valid_i && !iss_stall_o && |iss_rd_i) ? NREG'(1) << iss_rd_i : '0;

    // Set wins over clear because it is applied after the clear; x0 is never tracked.
    always_comb begin
        busy_d    = (busy_eff | set_mask) & ~NREG'(1);
        rr_ptr_d  = xfer ? ((int'(gnt_idx) == NUM_REQ - 1) ? '0 : IW'(gnt_idx + 1'b1)) : rr_ptr_q;
        wr_en_d   = xfer && |g_addr;
        wr_addr_d = xfer ? g_addr : wr_addr_q;
        wr_data_d = xfer ? g_data : wr_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign rf_wr_en_o   = wr_en_q;
    assign rf_wr_addr_o = wr_addr_q;
    assign rf_wr_data_o = wr_data_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: scoreboard bench for rf_wb_sched with directed scenarios and randomized traffic.
module tb_rf_wb_sched;

    logic        clk;
    logic        rst_n;
    logic [2:0]  wb_valid_i;
    logic [14:0] wb_addr_i;
    logic [95:0] wb_data_i;
    logic [2:0]  wb_ready_o;
    logic        rf_wr_en_o;
    logic [4:0]  rf_wr_addr_o;
    logic [31:0] rf_wr_data_o;
    logic        iss_valid_i;
    logic [4:0]  iss_rd_i, iss_rs1_i, iss_rs2_i;
    logic        iss_stall_o;
    logic [31:0] busy_o;

    rf_wb_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_valid_i   (wb_valid_i),
        .wb_addr_i    (wb_addr_i),
        .wb_data_i    (wb_data_i),
        .wb_ready_o   (wb_ready_o),
        .rf_wr_en_o   (rf_wr_en_o),
        .rf_wr_addr_o (rf_wr_addr_o),
        .rf_wr_data_o (rf_wr_data_o),
        .iss_valid_i  (iss_valid_i),
        .iss_rd_i     (iss_rd_i),
        .iss_rs1_i    (iss_rs1_i),
        .iss_rs2_i    (iss_rs2_i),
        .iss_stall_o  (iss_stall_o),
        .busy_o       (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          m_ptr = 0;
    logic [31:0] m_busy = '0;
    bit          m_wr_en = 0;
    logic [4:0]  m_wr_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_busy  = '0;
        m_wr_en = 0;
        exp_q.delete();
    endtask

    // Monitor: every register-file write must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rf_wr_en_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL wr_unexpected: got x%0d=%h expected no write", rf_wr_addr_o, rf_wr_data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {27'b0, rf_wr_addr_o}, {27'b0, e.a});
                    chk("wr_data", rf_wr_data_o, e.d);
                end
            end
        end
    end

    // One clock of stimulus; checks combinational outputs and the registered scoreboard, then advances the model.
    task automatic cycle(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                         input logic iv, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        int          g;
        logic [31:0] beff;
        bit          exp_stall;
        wr_t         w;
        @(negedge clk);
        chk("busy", busy_o, m_busy);
        wb_valid_i  = v;
        wb_addr_i   = a;
        wb_data_i   = d;
        iss_valid_i = iv;
        iss_rd_i    = rd;
        iss_rs1_i   = rs1;
        iss_rs2_i   = rs2;
        #1;
        g = -1;
        for (int k = 0; k < 3; k++)
            if (g < 0 && v[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
        chk("ready", {29'b0, wb_ready_o}, g < 0 ? 32'd0 : 32'd1 << g);
        beff = m_busy;
        if (m_wr_en) beff[m_wr_addr] = 1'b0;
        exp_stall = iv && ((rs1 != 0 && beff[rs1]) || (rs2 != 0 && beff[rs2]) || (rd != 0 && beff[rd]));
        chk("stall", {31'b0, iss_stall_o}, {31'b0, exp_stall});
        if (g >= 0) begin
            w.a       = a[g*5 +: 5];
            w.d       = d[g*32 +: 32];
            m_ptr     = (g + 1) % 3;
            m_wr_en   = (w.a != 0);
            m_wr_addr = w.a;
            if (m_wr_en) exp_q.push_back(w);
        end else begin
            m_wr_en = 0;
        end
        m_busy = beff;
        if (iv && !exp_stall && rd != 0) m_busy[rd] = 1'b1;
    endtask

    task automatic idle();
        cycle(3'b000, '0, '0, 1'b0, '0, '0, '0);
    endtask

    function automatic logic [4:0] rreg();
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        wb_valid_i  = '0;
        wb_addr_i   = '0;
        wb_data_i   = '0;
        iss_valid_i = 1'b0;
        iss_rd_i    = '0;
        iss_rs1_i   = '0;
        iss_rs2_i   = '0;
        rst_n       = 1'b0;
        model_reset();
        // Requests and issue held active during reset must be neither accepted nor stalled.
        wb_valid_i  = 3'b111;
        wb_addr_i   = {5'd3, 5'd2, 5'd1};
        iss_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy_o, 32'd0);
        chk("rst_wr_en", {31'b0, rf_wr_en_o}, 32'd0);
        chk("rst_wr_addr", {27'b0, rf_wr_addr_o}, 32'd0);
        chk("rst_wr_data", rf_wr_data_o, 32'd0);
        chk("rst_ready", {29'b0, wb_ready_o}, 32'd0);
        chk("rst_stall", {31'b0, iss_stall_o}, 32'd0);
        wb_valid_i  = '0;
        iss_valid_i = 1'b0;
        rst_n       = 1'b1;

        // Round-robin burst: grants 0,1,2,0 and writes x1,x2,x3,x1.
        repeat (4) cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0, '0, '0, '0);
        // Write to x0 is accepted but not performed.
        cycle(3'b010, '0, {32'h0, 32'hFFFF_FFFF, 32'h0}, 1'b0, '0, '0, '0);
        idle();
        // RAW stall on x5 released in the cycle the LSU write of x5 is on the port.
        cycle(3'b000, '0, '0, 1'b1, 5'd5, 5'd0, 5'd0);
        repeat (2) cycle(3'b000, '0, '0, 1'b1, 5'd9, 5'd5, 5'd0);
        cycle(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'h5555, 32'h0}, 1'b1, 5'd9, 5'd5, 5'd0);
        cycle(3'b000, '0, '0, 1'b1, 5'd9, 5'd5, 5'd0);
        idle();
        // Same-cycle clear and set of x7 leaves it set.
        cycle(3'b000, '0, '0, 1'b1, 5'd7, 5'd0, 5'd0);
        cycle(3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h77}, 1'b0, '0, '0, '0);
        cycle(3'b000, '0, '0, 1'b1, 5'd7, 5'd0, 5'd0);
        idle();
        idle();

        for (int n = 0; n < 3000; n++)
            cycle(3'($urandom_range(0, 7)), {rreg(), rreg(), rreg()},
                  {32'($urandom), 32'($urandom), 32'($urandom)},
                  1'($urandom_range(0, 1)), rreg(), rreg(), rreg());
        repeat (2) idle();

        // Asynchronous reset mid-burst with x4..x7 pending and a grant outstanding.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int r = 4; r < 8; r++) cycle(3'b000, '0, '0, 1'b1, 5'(r), 5'd0, 5'd0);
        cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("pre_rst_busy", busy_o, 32'h0000_00F0);
        wb_valid_i  = 3'b111;
        iss_valid_i = 1'b1;
        iss_rs1_i   = 5'd4;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy", busy_o, 32'd0);
        chk("async_wr_en", {31'b0, rf_wr_en_o}, 32'd0);
        chk("async_ready", {29'b0, wb_ready_o}, 32'd0);
        chk("async_stall", {31'b0, iss_stall_o}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        wb_valid_i  = '0;
        iss_valid_i = 1'b0;
        rst_n       = 1'b1;
        cycle(3'b110, {5'd3, 5'd2, 5'd1}, {32'h30, 32'h20, 32'h10}, 1'b0, '0, '0, '0);
        chk("post_rst_ptr", {30'b0, m_ptr[1:0]}, 32'd2);
        repeat (3) idle();
        @(negedge clk);
        chk("final_busy", busy_o, m_busy);
        chk("pending_writes", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
